// File: rtl/dmem_responder.sv
// Single-port data memory responder with a fixed access latency, sub-word access,
// sign/zero extension and fault detection for misaligned, out-of-range or illegal requests.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_type,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int unsigned AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [2:0] TypeB  = 3'd0;
    localparam logic [2:0] TypeH  = 3'd1;
    localparam logic [2:0] TypeW  = 3'd2;
    localparam logic [2:0] TypeBu = 3'd4;
    localparam logic [2:0] TypeHu = 3'd5;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [2:0]  type_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic [AW-1:0] idx;
    logic [1:0]    lane;
    logic          out_of_range;
    logic          access_err;
    logic          commit;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_data;
    logic [3:0]    st_be;
    logic [31:0]   st_data;

    assign idx          = addr_q[AW+1:2];
    assign lane         = addr_q[1:0];
    assign out_of_range = (addr_q >> (AW + 2)) != 32'd0;
    assign commit       = (state_q == StWait) && (cnt_q == 4'd0);
    assign req_ready    = (state_q == StIdle);

    always_comb begin
        access_err = out_of_range;
        case (type_q)
            TypeB:   ;
            TypeH:   if (lane[0]) access_err = 1'b1;
            TypeW:   if (lane != 2'b00) access_err = 1'b1;
            TypeBu:  if (we_q) access_err = 1'b1;
            TypeHu:  if (we_q || lane[0]) access_err = 1'b1;
            default: access_err = 1'b1;
        endcase
    end

    assign rd_word = mem[idx];

    always_comb begin
        rd_byte = rd_word[7:0];
        case (lane)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = lane[1] ? rd_word[31:16] : rd_word[15:0];
    end

    always_comb begin
        load_data = 32'd0;
        case (type_q)
            TypeB:   load_data = {{24{rd_byte[7]}}, rd_byte};
            TypeH:   load_data = {{16{rd_half[15]}}, rd_half};
            TypeW:   load_data = rd_word;
            TypeBu:  load_data = {24'd0, rd_byte};
            TypeHu:  load_data = {16'd0, rd_half};
            default: load_data = 32'd0;
        endcase
    end

    // Store data is replicated across lanes so the byte enables alone pick the target bytes.
    always_comb begin
        st_be   = 4'b0000;
        st_data = wdata_q;
        case (type_q)
            TypeB: begin
                st_be       = 4'b0001 << lane;
                st_data     = {4{wdata_q[7:0]}};
            end
            TypeH: begin
                st_be       = lane[1] ? 4'b1100 : 4'b0011;
                st_data     = {2{wdata_q[15:0]}};
            end
            TypeW: begin
                st_be       = 4'b1111;
                st_data     = wdata_q;
            end
            default: begin
                st_be       = 4'b0000;
                st_data     = wdata_q;
            end
        endcase
    end

    // Array has no reset; an aborted transaction never reaches commit because reset forces IDLE.
    always_ff @(posedge clk) begin
        if (commit && we_q && !access_err) begin
            for (int b = 0; b < 4; b++) begin
                if (st_be[b]) begin
                    mem[idx][b*8 +: 8] <= st_data[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            we_q       <= 1'b0;
            type_q     <= 3'd0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            resp_valid <= 1'b0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        type_q  <= req_type;
                        addr_q  <= req_addr;
                        wdata_q <= req_wdata;
                        cnt_q   <= 4'(LATENCY - 1);
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q    <= StResp;
                        resp_valid <= 1'b1;
                        resp_err   <= access_err;
                        resp_rdata <= (we_q || access_err) ? 32'd0 : load_data;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    if (resp_ready) begin
                        state_q    <= StIdle;
                        resp_valid <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
